// File: rtl/flow_sched_pkg.sv
// Shared types and width helpers for the channel flow scheduler.
package flow_sched_pkg;

    // Sequencer phases for one dosing transaction.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DOSE  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Storage widths of a tracked plug; the live widths (SRC_W, CNT_W)
    // must not exceed these and occupy the low bits.
    localparam int PLUG_SRC_W = 8;
    localparam int PLUG_CNT_W = 32;

    typedef struct packed {
        logic [PLUG_SRC_W-1:0] src;
        logic [PLUG_CNT_W-1:0] countdown;
    } plug_t;

    // Source id width: at least one bit even for two sources.
    function automatic int src_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Width needed to hold a count from 0 to m inclusive.
    function automatic int occ_width(input int m);
        return (m > 1) ? $clog2(m + 1) : 1;
    endfunction

    // Smallest counter width able to hold the given cycle count.
    function automatic int cnt_width(input int max_cycles);
        return (max_cycles > 1) ? $clog2(max_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/channel_flow_scheduler_plug_tracker.sv
// In-order FIFO of dosed plugs, each counting down its channel transit.
// The head raises out_valid in the cycle its countdown reads zero and is
// popped on the closing edge of that cycle.
module plug_tracker
    import flow_sched_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int SRC_W          = 2,
    parameter int CNT_W          = 16,
    parameter int TRANSIT_CYCLES = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [SRC_W-1:0] push_src,
    output logic             out_valid,
    output logic [SRC_W-1:0] out_src
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = occ_width(DEPTH);
    // The pushed entry is already one cycle into its transit when first
    // visible, so it is loaded one short: zero is reached exactly
    // TRANSIT_CYCLES cycles after the pushing (last flush) cycle.
    localparam logic [CNT_W-1:0] TRANSIT_LOAD = CNT_W'(TRANSIT_CYCLES - 1);

    plug_t            mem     [DEPTH];
    plug_t            mem_nxt [DEPTH];
    plug_t            head_nxt;
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt;
    logic [OCC_W-1:0] count, count_nxt;
    logic             pop;
    logic             valid_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    // The registered head-expiry flag is exactly the pop of this cycle.
    assign pop = out_valid;

    // Next FIFO contents: age every pending countdown, pop, then push.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_nxt[i] = mem[i];
            if (mem[i].countdown != '0)
                mem_nxt[i].countdown = mem[i].countdown - PLUG_CNT_W'(1);
        end
        rd_nxt = pop ? ptr_inc(rd_ptr) : rd_ptr;
        wr_nxt = wr_ptr;
        if (push) begin
            mem_nxt[wr_ptr].src       = PLUG_SRC_W'(push_src);
            mem_nxt[wr_ptr].countdown = PLUG_CNT_W'(TRANSIT_LOAD);
            wr_nxt                    = ptr_inc(wr_ptr);
        end
        count_nxt = count + OCC_W'(push) - OCC_W'(pop);
        head_nxt  = mem_nxt[rd_nxt];
        valid_nxt = (count_nxt != '0) && (head_nxt.countdown == '0);
    end

    // Slot payloads carry no reset; occupancy and pointers define liveness.
    always_ff @(posedge clk) begin
        mem <= mem_nxt;
    end

    // Occupancy, pointers and the registered arrival pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_src   <= '0;
        end else begin
            rd_ptr    <= rd_nxt;
            wr_ptr    <= wr_nxt;
            count     <= count_nxt;
            out_valid <= valid_nxt;
            out_src   <= valid_nxt ? head_nxt.src[SRC_W-1:0] : '0;
        end
    end

    // Slots are reserved at grant time, so a push never finds the FIFO full.
    assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count == OCC_W'(DEPTH))));

    // An arrival can only come from a live entry.
    assert property (@(posedge clk) disable iff (rst)
        !(pop && (count == '0)));

endmodule

// File: rtl/channel_flow_scheduler.sv
// Doses fluid from N_SRC reservoirs into one shared channel chain:
// round-robin grant, timed inlet dose, buffer flush, settling gap, and
// tracking of each plug until it reaches the outlet.
module channel_flow_scheduler
    import flow_sched_pkg::*;
#(
    parameter  int N_SRC          = 3,
    parameter  int DOSE_CYCLES    = 8,
    parameter  int FLUSH_CYCLES   = 4,
    parameter  int GAP_CYCLES     = 2,
    parameter  int TRANSIT_CYCLES = 40,
    parameter  int MAX_INFLIGHT   = 4,
    parameter  int CNT_W          = 16,
    localparam int SRC_W          = src_width(N_SRC),
    localparam int OCC_W          = occ_width(MAX_INFLIGHT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_SRC-1:0] req,
    output logic [N_SRC-1:0] inlet_valve,
    output logic             flush_valve,
    output logic             busy,
    output logic [SRC_W-1:0] grant_src,
    output logic [OCC_W-1:0] inflight,
    output logic             out_valid,
    output logic [SRC_W-1:0] out_src
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] winner;
    logic             found;
    logic             grant;
    logic             push;
    int               idx;

    // Round-robin search: first requester at or after the pointer, wrapping.
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = (int'(rr_ptr) + k) % N_SRC;
            if (!found && req[idx]) begin
                winner = SRC_W'(idx);
                found  = 1'b1;
            end
        end
    end

    // A slot is reserved at grant; an arrival this cycle does not free one yet.
    assign grant = (state == ST_IDLE) && en && found &&
                   (inflight < OCC_W'(MAX_INFLIGHT));

    // The plug enters the channel on the closing edge of the last flush cycle.
    assign push = (state == ST_FLUSH) && (cnt == CNT_W'(FLUSH_CYCLES - 1));

    // Dose sequencer with registered valve and busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            rr_ptr      <= '0;
            grant_src   <= '0;
            inlet_valve <= '0;
            flush_valve <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        state       <= ST_DOSE;
                        cnt         <= '0;
                        grant_src   <= winner;
                        rr_ptr      <= (int'(winner) == N_SRC - 1) ? '0 : winner + SRC_W'(1);
                        inlet_valve <= N_SRC'(1) << winner;
                        busy        <= 1'b1;
                    end
                end
                ST_DOSE: begin
                    if (cnt == CNT_W'(DOSE_CYCLES - 1)) begin
                        state       <= ST_FLUSH;
                        cnt         <= '0;
                        inlet_valve <= '0;
                        flush_valve <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_FLUSH: begin
                    if (push) begin
                        flush_valve <= 1'b0;
                        cnt         <= '0;
                        if (GAP_CYCLES == 0) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_GAP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    cnt         <= '0;
                    inlet_valve <= '0;
                    flush_valve <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    // Slots held from grant until the plug's arrival pops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else if (grant && !out_valid) begin
            inflight <= inflight + OCC_W'(1);
        end else if (!grant && out_valid) begin
            inflight <= inflight - OCC_W'(1);
        end
    end

    plug_tracker #(
        .DEPTH          (MAX_INFLIGHT),
        .SRC_W          (SRC_W),
        .CNT_W          (CNT_W),
        .TRANSIT_CYCLES (TRANSIT_CYCLES)
    ) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_src  (grant_src),
        .out_valid (out_valid),
        .out_src   (out_src)
    );

    // The sequencer never opens an inlet and the flush valve together.
    assert property (@(posedge clk) disable iff (rst)
        !((inlet_valve != '0) && flush_valve));

endmodule

// File: doc/channel_flow_scheduler.md
Name: channel_flow_scheduler

Overview:
- Sequences fluid dosing from N_SRC inlet reservoirs into one shared serpentine channel chain.
- Round-robin arbitrates inlet requests and drives one-hot inlet valves for a fixed dose, then a buffer flush, then a settling gap.
- Tracks each dosed plug through the chain's fixed transit time and flags its arrival, with source id, at the chain outlet.
- Sits between the reservoir/valve actuators and the outlet sampling/detection logic.

Parameters:
- N_SRC, 3, number of inlet reservoirs/requesters (>=2).
- DOSE_CYCLES, 8, cycles the granted inlet valve stays open (>=1).
- FLUSH_CYCLES, 4, cycles the buffer flush valve stays open after a dose (>=1).
- GAP_CYCLES, 2, cycles with all valves closed after a flush (>=0).
- TRANSIT_CYCLES, 40, cycles from end of flush to plug arrival at the outlet (>=1).
- MAX_INFLIGHT, 4, maximum plugs dosed or in the channel at once (>=1).
- CNT_W, 16, width of all cycle counters; every *_CYCLES value is < 2**CNT_W.

Ports:
- clk, input, 1, sole clock, rising edge.
- rst, input, 1, synchronous, active-high reset.
- en, input, 1, permits new grants; a dose already started always completes.
- req, input, N_SRC, per-source dose request, level-sensitive.
- inlet_valve, output, N_SRC, one-hot or zero; open inlet valve.
- flush_valve, output, 1, buffer flush valve open.
- busy, output, 1, state is not IDLE.
- grant_src, output, SRC_W = max(1, clog2(N_SRC)), source of the current or most recent grant.
- inflight, output, clog2(MAX_INFLIGHT+1), occupied plug slots.
- out_valid, output, 1, single-cycle pulse: a plug reaches the outlet.
- out_src, output, SRC_W, source id of the arriving plug; valid only with out_valid.

Behaviour:
- All outputs are registered. Reset values are 0 for every output.
- At reset: state = IDLE, RR pointer = 0, plug tracker empty.
- Reset asserted mid-dose or with plugs in flight:
  - all valves close in the cycle after the reset edge;
  - tracked plugs are discarded, and no out_valid is produced for them.
- FSM states: IDLE, DOSE, FLUSH, GAP.
- IDLE, grant condition: en && |req && inflight < MAX_INFLIGHT.
  - The registered inflight value is used. A pop in the same cycle does not free a slot.
  - Winner: the first requesting source at or after the RR pointer, with wrap-around.
  - On the grant edge: grant_src = winner, RR pointer = winner+1 mod N_SRC, inflight += 1, state -> DOSE.
- DOSE: inlet_valve[grant_src] = 1 for exactly DOSE_CYCLES cycles, then -> FLUSH.
  - req changes during DOSE are ignored.
- FLUSH: flush_valve = 1 for exactly FLUSH_CYCLES cycles.
  - On the last FLUSH cycle, push {grant_src, TRANSIT_CYCLES} into the tracker.
  - Then -> GAP, or -> IDLE if GAP_CYCLES = 0.
- GAP: all valves closed for GAP_CYCLES cycles, then -> IDLE.
- Valve exclusivity: inlet_valve and flush_valve are never both nonzero in the same cycle.
- Minimum grant-to-grant spacing: DOSE_CYCLES + FLUSH_CYCLES + GAP_CYCLES + 1 cycles.
- Tracker: in-order FIFO of depth MAX_INFLIGHT holding {src, countdown}.
  - Every nonzero countdown decrements each cycle.
  - out_valid/out_src assert in the cycle the head countdown is 0; the head pops on that edge and inflight -= 1.
  - Timing: for a grant decided in IDLE cycle t, DOSE occupies t+1..t+DOSE_CYCLES and FLUSH follows; out_valid falls TRANSIT_CYCLES cycles after the last FLUSH cycle.
  - Push and pop on the same edge are legal; inflight is then unchanged.
  - The tracker cannot overflow, because slots are reserved at grant. An overflow is an assertion failure.
  - Pop when empty is impossible; guard it with an assertion.
- en low: no new grant. Current dose, flush, gap and tracking continue normally.

Decomposition:
- Package flow_sched_pkg holds:
  - state enum (IDLE, DOSE, FLUSH, GAP);
  - SRC_W/CNT_W derivation functions;
  - plug entry struct {src, countdown}.
- Sub-module plug_tracker: FIFO plus per-entry countdown, push/pop, head-expiry out_valid.
- Top module holds the FSM, the RR arbiter and the valve output registers.

Test Plan:
- Single request at defaults:
  - Stimulus: req=001 held from reset release; first grant decided at cycle 2.
  - Response: inlet_valve=001 for cycles 3-10, flush_valve for cycles 11-14, out_valid with out_src=0 at cycle 54; inflight returns 1 -> 0 after the pop.
- Round-robin fairness:
  - Stimulus: req=111 held.
  - Response: grant order 0,1,2,0,...; grants spaced exactly 15 cycles apart; out_src sequence matches the grant order.
- Occupancy limit:
  - Stimulus: MAX_INFLIGHT=2, TRANSIT_CYCLES=100, req=111 held.
  - Response: two grants, then busy=0 with no grant while inflight=2; the third grant occurs the cycle after the first out_valid.
- Request withdrawal and en:
  - Stimulus: drop req mid-DOSE.
  - Response: the full 8-cycle dose and 4-cycle flush still occur.
  - Stimulus: en=0 in IDLE with req=010.
  - Response: no grant until en returns to 1.
- Reset mid-operation:
  - Stimulus: assert rst during FLUSH with 2 plugs tracked.
  - Response: all outputs 0 the next cycle; no out_valid ever appears for the discarded plugs.
- Edge parameters:
  - Stimulus: GAP_CYCLES=0, TRANSIT_CYCLES=1, req=001.
  - Response: FLUSH goes directly to IDLE; out_valid appears 1 cycle after the last flush cycle; push and pop on the same edge keep inflight correct.
